// File: rtl/mysystem_hps_pio_out_multi.sv
// Multi-channel Avalon-MM output PIO. Each channel has a shadow register written by software
// and an active register driving out_port, loaded on a frame_sync rise or a CTRL commit.
module mysystem_hps_pio_out_multi #(
  parameter int               WIDTH       = 10,
  parameter int               NUM_CH      = 3,
  parameter int               SYNC_COMMIT = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [4:0]              address,
  input  logic                    chipselect,
  input  logic                    write_n,
  input  logic [31:0]             writedata,
  output logic [31:0]             readdata,
  input  logic                    frame_sync,
  output logic [NUM_CH*WIDTH-1:0] out_port,
  output logic                    update_pending
);

  logic [2:0]       ch;
  logic [1:0]       off;
  logic             ch_valid;
  logic             wr_en;
  logic             shadow_wr;
  logic             sw_commit;
  logic             hw_commit;
  logic             commit;
  logic [WIDTH-1:0] wdata;
  logic             unused_wdata;

  logic [WIDTH-1:0] shadow_q [NUM_CH];
  logic [WIDTH-1:0] shadow_d [NUM_CH];
  logic [WIDTH-1:0] active_q [NUM_CH];
  logic [WIDTH-1:0] active_d [NUM_CH];
  logic             pending_q, pending_d;
  logic             fsync_dly_q;

  assign ch           = address[4:2];
  assign off          = address[1:0];
  assign ch_valid     = ({29'd0, ch} < 32'(NUM_CH));
  assign wr_en        = chipselect && !write_n && ch_valid;
  assign shadow_wr    = wr_en && (off != 2'd3);
  assign wdata        = writedata[WIDTH-1:0];
  assign unused_wdata = ^writedata;

  // Commits only exist in double-buffered mode; frame_sync needs a fresh rising edge.
  assign hw_commit = frame_sync && !fsync_dly_q;
  assign sw_commit = wr_en && (off == 2'd3) && writedata[0];
  assign commit    = (SYNC_COMMIT != 0) && (hw_commit || sw_commit);

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      shadow_d[k] = shadow_q[k];
      if (wr_en && (ch == 3'(k))) begin
        case (off)
          2'd0:    shadow_d[k] = wdata;
          2'd1:    shadow_d[k] = shadow_q[k] | wdata;
          2'd2:    shadow_d[k] = shadow_q[k] & ~wdata;
          default: shadow_d[k] = shadow_q[k];
        endcase
      end
    end
  end

  // Active takes the pre-write shadow on a commit, so a coincident write waits a frame.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      active_d[k] = active_q[k];
      if (SYNC_COMMIT == 0) begin
        active_d[k] = shadow_d[k];
      end else if (commit) begin
        active_d[k] = shadow_q[k];
      end
    end
  end

  always_comb begin
    pending_d = pending_q;
    if (SYNC_COMMIT == 0) begin
      pending_d = 1'b0;
    end else if (shadow_wr) begin
      pending_d = 1'b1;
    end else if (commit) begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_CH; k++) begin
        shadow_q[k] <= RESET_VALUE;
        active_q[k] <= RESET_VALUE;
      end
      pending_q   <= 1'b0;
      fsync_dly_q <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        shadow_q[k] <= shadow_d[k];
        active_q[k] <= active_d[k];
      end
      pending_q   <= pending_d;
      fsync_dly_q <= frame_sync;
    end
  end

  always_comb begin
    readdata = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch == 3'(k)) begin
        if (off == 2'd0) begin
          readdata[WIDTH-1:0] = shadow_q[k];
        end else if (off == 2'd3) begin
          readdata[WIDTH-1:0] = active_q[k];
        end
      end
    end
  end

  always_comb begin
    out_port = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      out_port[k*WIDTH +: WIDTH] = active_q[k];
    end
  end

  assign update_pending = pending_q;

endmodule

// File: tb/tb_mysystem_hps_pio_out_multi.sv
// Directed bench: a double-buffered instance and an immediate-mode instance share the bus.
module tb_mysystem_hps_pio_out_multi;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic        frame_sync;
  logic [31:0] rd0, rd1;
  logic [29:0] out0, out1;
  logic        pend0, pend1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mysystem_hps_pio_out_multi #(.WIDTH(10), .NUM_CH(3), .SYNC_COMMIT(1)) dut0 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd0), .frame_sync(frame_sync),
    .out_port(out0), .update_pending(pend0)
  );

  mysystem_hps_pio_out_multi #(.WIDTH(10), .NUM_CH(3), .SYNC_COMMIT(0)) dut1 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd1), .frame_sync(frame_sync),
    .out_port(out1), .update_pending(pend1)
  );

  function automatic logic [4:0] A(input int c, input int o);
    return 5'(c * 4 + o);
  endfunction

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d, input logic fs);
    @(negedge clk);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    frame_sync = fs;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic tick(input logic fs);
    @(negedge clk);
    frame_sync = fs;
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input logic [4:0] a);
    @(negedge clk);
    address = a;
    #1;
  endtask

  task automatic test_reset;
    checks++; if (out0 !== 30'd0) begin errors++; $display("FAIL reset_out0 got=%h exp=%h", out0, 30'd0); end
    checks++; if (pend0 !== 1'b0) begin errors++; $display("FAIL reset_pend0 got=%b exp=0", pend0); end
    checks++; if (out1 !== 30'd0) begin errors++; $display("FAIL reset_out1 got=%h exp=%h", out1, 30'd0); end
  endtask

  task automatic test_data_commit;
    write_reg(A(0, 0), 32'h3FF, 1'b0);
    checks++; if (out0[9:0] !== 10'h000) begin errors++; $display("FAIL data_hold got=%h exp=000", out0[9:0]); end
    checks++; if (pend0 !== 1'b1) begin errors++; $display("FAIL data_pend got=%b exp=1", pend0); end
    tick(1'b1);
    checks++; if (out0[9:0] !== 10'h3FF) begin errors++; $display("FAIL fs_commit got=%h exp=3ff", out0[9:0]); end
    checks++; if (pend0 !== 1'b0) begin errors++; $display("FAIL fs_pend_clr got=%b exp=0", pend0); end
    tick(1'b0);
  endtask

  task automatic test_set_clear;
    write_reg(A(1, 1), 32'h00F, 1'b0);
    write_reg(A(1, 2), 32'h003, 1'b0);
    set_addr(A(1, 0));
    checks++; if (rd0 !== 32'h00C) begin errors++; $display("FAIL setclr_shadow got=%h exp=0000000c", rd0); end
    set_addr(A(1, 1));
    checks++; if (rd0 !== 32'h0) begin errors++; $display("FAIL set_read_zero got=%h exp=0", rd0); end
    write_reg(A(1, 3), 32'h1, 1'b0);
    checks++; if (out0[19:10] !== 10'h00C) begin errors++; $display("FAIL ctrl_commit got=%h exp=00c", out0[19:10]); end
    checks++; if (pend0 !== 1'b0) begin errors++; $display("FAIL ctrl_pend got=%b exp=0", pend0); end
    set_addr(A(1, 3));
    checks++; if (rd0 !== 32'h00C) begin errors++; $display("FAIL ctrl_readback got=%h exp=0000000c", rd0); end
  endtask

  task automatic test_coincident;
    write_reg(A(2, 0), 32'h0AA, 1'b0);
    tick(1'b1);
    tick(1'b0);
    checks++; if (out0[29:20] !== 10'h0AA) begin errors++; $display("FAIL coin_pre got=%h exp=0aa", out0[29:20]); end
    write_reg(A(2, 0), 32'h155, 1'b1);
    checks++; if (out0[29:20] !== 10'h0AA) begin errors++; $display("FAIL coin_old got=%h exp=0aa", out0[29:20]); end
    checks++; if (pend0 !== 1'b1) begin errors++; $display("FAIL coin_pend got=%b exp=1", pend0); end
    tick(1'b0);
    tick(1'b1);
    checks++; if (out0[29:20] !== 10'h155) begin errors++; $display("FAIL coin_next got=%h exp=155", out0[29:20]); end
    tick(1'b0);
  endtask

  task automatic test_held_sync;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) write_reg(A(0, 0), 32'h111, 1'b1);
      else tick(1'b1);
    end
    checks++; if (out0[9:0] !== 10'h3FF) begin errors++; $display("FAIL held_no_commit got=%h exp=3ff", out0[9:0]); end
    checks++; if (pend0 !== 1'b1) begin errors++; $display("FAIL held_pend got=%b exp=1", pend0); end
    tick(1'b0);
    checks++; if (out0[9:0] !== 10'h3FF) begin errors++; $display("FAIL held_fall got=%h exp=3ff", out0[9:0]); end
    tick(1'b1);
    checks++; if (out0[9:0] !== 10'h111) begin errors++; $display("FAIL held_rerise got=%h exp=111", out0[9:0]); end
    tick(1'b0);
  endtask

  task automatic test_bad_channel;
    logic [29:0] exp_out;
    exp_out = {10'h155, 10'h00C, 10'h111};
    write_reg(A(5, 0), 32'hFFFF, 1'b0);
    write_reg(A(5, 3), 32'h1, 1'b0);
    checks++; if (out0 !== exp_out) begin errors++; $display("FAIL bad_ch_out got=%h exp=%h", out0, exp_out); end
    checks++; if (pend0 !== 1'b0) begin errors++; $display("FAIL bad_ch_pend got=%b exp=0", pend0); end
    set_addr(A(5, 0));
    checks++; if (rd0 !== 32'h0) begin errors++; $display("FAIL bad_ch_read got=%h exp=0", rd0); end
    set_addr(A(0, 0));
    checks++; if (rd0 !== 32'h111) begin errors++; $display("FAIL bad_ch_alias got=%h exp=00000111", rd0); end
  endtask

  task automatic test_high_bits;
    write_reg(A(0, 0), 32'hFFFF_FC00, 1'b0);
    set_addr(A(0, 0));
    checks++; if (rd0 !== 32'h0) begin errors++; $display("FAIL high_bits got=%h exp=0", rd0); end
    write_reg(A(0, 3), 32'h2, 1'b0);
    checks++; if (out0[9:0] !== 10'h111) begin errors++; $display("FAIL ctrl_bit0_clear got=%h exp=111", out0[9:0]); end
    write_reg(A(0, 3), 32'h1, 1'b0);
    checks++; if (out0[9:0] !== 10'h000) begin errors++; $display("FAIL high_commit got=%h exp=000", out0[9:0]); end
  endtask

  task automatic test_immediate;
    write_reg(A(0, 0), 32'h2A5, 1'b0);
    checks++; if (out1[9:0] !== 10'h2A5) begin errors++; $display("FAIL imm_out got=%h exp=2a5", out1[9:0]); end
    checks++; if (pend1 !== 1'b0) begin errors++; $display("FAIL imm_pend got=%b exp=0", pend1); end
    checks++; if (out0[9:0] !== 10'h000) begin errors++; $display("FAIL sync_hold got=%h exp=000", out0[9:0]); end
    set_addr(A(0, 3));
    checks++; if (rd1 !== 32'h2A5) begin errors++; $display("FAIL imm_read got=%h exp=000002a5", rd1); end
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (out1 !== 30'd0) begin errors++; $display("FAIL async_out1 got=%h exp=0", out1); end
    checks++; if (out0 !== 30'd0) begin errors++; $display("FAIL async_out0 got=%h exp=0", out0); end
    checks++; if (pend0 !== 1'b0) begin errors++; $display("FAIL async_pend got=%b exp=0", pend0); end
    @(negedge clk);
    reset_n = 1'b1;
    tick(1'b0);
    tick(1'b0);
    set_addr(A(0, 0));
    checks++; if (rd0 !== 32'h0) begin errors++; $display("FAIL rst_shadow got=%h exp=0", rd0); end
    write_reg(A(0, 0), 32'h1A0, 1'b0);
    checks++; if (out0[9:0] !== 10'h000) begin errors++; $display("FAIL rst_no_commit got=%h exp=000", out0[9:0]); end
    tick(1'b1);
    checks++; if (out0[9:0] !== 10'h1A0) begin errors++; $display("FAIL rst_recommit got=%h exp=1a0", out0[9:0]); end
    tick(1'b0);
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    frame_sync = 1'b0;
    #12;
    test_reset();
    @(negedge clk);
    reset_n = 1'b1;
    test_data_commit();
    test_set_clear();
    test_coincident();
    test_held_sync();
    test_bad_channel();
    test_high_bits();
    test_immediate();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mysystem_hps_pio_out_multi.md
MYSYSTEM_HPS_PIO_OUT_MULTI -- requirements
Module: mysystem_hps_pio_out_multi

Interface
REQ-001 SHALL have parameter WIDTH, default 10, bits per channel (legal 1..32).
REQ-002 SHALL have parameter NUM_CH, default 3, number of output channels (legal 1..8).
REQ-003 SHALL have parameter SYNC_COMMIT, default 1; 1 = double-buffered commit, 0 = immediate.
REQ-004 SHALL have parameter RESET_VALUE, default 0, WIDTH-bit reset value of every shadow and active register.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port address  input  5  bits[4:2] = channel index, bits[1:0] = register offset.
REQ-008 SHALL have port chipselect  input  1  Avalon-MM slave select.
REQ-009 SHALL have port write_n  input  1  active-low write strobe, qualified by chipselect.
REQ-010 SHALL have port writedata  input  32  write data.
REQ-011 SHALL have port readdata  output  32  combinational read data, zero-latency, zero-extended.
REQ-012 SHALL have port frame_sync  input  1  commit request, synchronous to clk.
REQ-013 SHALL have port out_port  output  NUM_CH*WIDTH  active registers; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-014 SHALL have port update_pending  output  1  high while any shadow differs in history from the last commit.

Function
REQ-015 SHALL decode a write as chipselect=1 and write_n=0; at most one register is written per cycle.
REQ-016 SHALL implement per-channel offsets: 0 DATA (write loads shadow with writedata[WIDTH-1:0]; read returns shadow), 1 SET (shadow |= writedata bits), 2 CLEAR (shadow &= ~writedata bits), 3 CTRL.
REQ-017 SHALL treat a CTRL write with writedata[0]=1 on any valid channel as a software commit of all channels; CTRL reads return active register of that channel.
REQ-018 SHALL return 0 on SET/CLEAR reads and ignore writedata bits above WIDTH-1.
REQ-019 SHALL ignore writes and return 0 on reads when channel index >= NUM_CH.
REQ-020 SHALL register frame_sync into frame_sync_d (reset 0) and define a hardware commit as frame_sync=1 and frame_sync_d=0.
REQ-021 With SYNC_COMMIT=1, SHALL load every active register from its shadow on the clock edge where a hardware or software commit is present; active registers otherwise hold.
REQ-022 On a shadow write coincident with a commit, SHALL commit the pre-write shadow value; the new value waits for the next commit.
REQ-023 SHALL set update_pending on any DATA/SET/CLEAR write edge and clear it on a commit edge, with set winning when both occur in the same cycle.
REQ-024 With SYNC_COMMIT=0, SHALL load each active register from its shadow's new value on the same edge as the write (out_port changes one cycle after the write is presented), ignore frame_sync and CTRL commits, and hold update_pending at 0.
REQ-025 SHALL keep frame_sync held high from producing more than one commit; a new commit needs a low-to-high transition.
REQ-026 SHALL drive readdata combinationally from address with no chipselect qualification; unused bits 0.

Reset
REQ-027 On reset_n=0, SHALL immediately set all shadows and active registers to RESET_VALUE, update_pending to 0 and frame_sync_d to 0, regardless of clk.
REQ-028 Reset asserted mid-operation SHALL discard pending shadow contents; after release no commit occurs until a new frame_sync edge or CTRL write.

Verification
REQ-029 Defaults: write DATA ch0 = 0x3FF -> out_port[9:0] stays 0, update_pending=1; pulse frame_sync -> out_port[9:0]=0x3FF one edge later, update_pending=0.
REQ-030 SET ch1 0x00F then CLEAR ch1 0x003 -> read offset 0 ch1 = 0x00C; CTRL write 0x1 -> out_port[19:10]=0x00C, readback offset 3 ch1 = 0x00C.
REQ-031 DATA ch2 = 0x155 on the same edge as frame_sync rise, shadow previously 0x0AA -> out_port[29:20]=0x0AA, update_pending stays 1; next frame_sync -> 0x155.
REQ-032 frame_sync held high 10 cycles, DATA ch0 write in cycle 3 -> no commit until frame_sync falls and rises again.
REQ-033 Access channel 5 (NUM_CH=3): write 0xFFFF -> no state change; read -> 0.
REQ-034 SYNC_COMMIT=0: write DATA ch0 = 0x2A5 -> out_port[9:0]=0x2A5 after that edge, update_pending=0; assert reset_n=0 asynchronously mid-cycle -> out_port=0 without a clock edge.
